// File: rtl/mtl_video_out.sv
// Clocked-video output stage: free-running panel raster, RGB888 stream input with
// start-of-frame locking, blanking on underflow and automatic resynchronisation.
module mtl_video_out #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10
) (
  input  logic        vid_clk,
  input  logic        reset,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        in_ready,
  output logic [23:0] vid_data,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err,
  output logic [1:0]  dbg_state
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Handshake: a beat transfers on a rising vid_clk edge where in_valid and
  // in_ready are both high; in_ready depends only on state and raster position.
  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [23:0] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [23:0] pix_q, pix_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic        uf_q, uf_d, se_q, se_d;
  logic        active, origin, frame_end, ready_int, xfer;

  always_comb begin
    active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    origin    = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    h_cnt_d = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;

    hs_d = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_d = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    case (state_q)
      ST_HUNT: ready_int = 1'b1;
      ST_RUN:  ready_int = active && !(origin && hold_valid_q);
      default: ready_int = 1'b0;
    endcase
    in_ready = ready_int && !reset;
    xfer     = in_valid && ready_int;

    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    pix_d        = 24'h0;
    de_d         = active && (state_q == ST_RUN);
    uf_d         = 1'b0;
    se_d         = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (xfer && in_sop) begin
          hold_d       = in_data;
          hold_valid_d = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (frame_end) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (origin && hold_valid_q) begin
          pix_d        = hold_q;
          hold_valid_d = 1'b0;
        end else if (active) begin
          if (!in_valid) begin
            uf_d         = 1'b1;
            state_d      = ST_HUNT;
            hold_valid_d = 1'b0;
          end else if (in_sop != origin) begin
            // sop must coincide exactly with the origin pixel; the beat is dropped
            se_d         = 1'b1;
            state_d      = ST_HUNT;
            hold_valid_d = 1'b0;
          end else begin
            pix_d = in_data;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge vid_clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      h_cnt_q      <= 11'd0;
      v_cnt_q      <= 11'd0;
      hold_q       <= 24'h0;
      hold_valid_q <= 1'b0;
      pix_q        <= 24'h0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      uf_q         <= 1'b0;
      se_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pix_q        <= pix_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      uf_q         <= uf_d;
      se_q         <= se_d;
    end
  end

  assign vid_data  = pix_q;
  assign vid_hs    = hs_q;
  assign vid_vs    = vs_q;
  assign vid_de    = de_q;
  assign underflow = uf_q;
  assign sync_err  = se_q;
  assign locked    = (state_q == ST_RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mtl_video_out.sv
// Directed bench for mtl_video_out on a reduced raster (H 16/2/3/2 = 23, V 6/1/2/1 = 10).
// Cycle c after reset release sits at raster (c%23, (c/23)%10); its outputs are seen in cycle c+1.
module tb_mtl_video_out;
  localparam logic [23:0] BASE = 24'hA00000;

  logic        vid_clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] in_data = 24'h0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_ready;
  logic [23:0] vid_data;
  logic        vid_hs, vid_vs, vid_de, locked, underflow, sync_err;
  logic [1:0]  dbg_state;

  always #5 vid_clk = ~vid_clk;

  mtl_video_out #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .vid_clk(vid_clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .vid_data(vid_data), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .locked(locked), .underflow(underflow), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  int src_k = 0;
  bit src_on = 1'b0;
  int drop_c = -1;
  int sop_c = -1;
  bit xfer_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Source: beat k carries BASE+k, sop on every 96th beat (one 16x6 frame).
  task automatic step();
    if (xfer_pend) src_k++;
    @(negedge vid_clk);
    cyc++;
    in_valid = src_on && (cyc != drop_c);
    in_data  = BASE + 24'(src_k);
    in_sop   = src_on && ((src_k % 96 == 0) || (cyc == sop_c));
    #1 xfer_pend = in_valid && in_ready;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  int hs_n, vs_n, de_n, data_n, rdy_lo, lock_n;

  initial begin
    repeat (3) @(posedge vid_clk);
    @(negedge vid_clk);
    #1 check_eq("rst_ready_low", in_ready, 0);
    reset = 1'b0;
    cyc = 0;
    #1;
    check_eq("rst_outputs", {vid_data, vid_hs, vid_vs, vid_de, locked, underflow, sync_err}, 0);
    check_eq("rst_state", dbg_state, 0);

    // Idle frame with no stream: raster timing only.
    hs_n = 0; vs_n = 0; de_n = 0; data_n = 0; rdy_lo = 0; lock_n = 0;
    for (int i = 0; i < 230; i++) begin
      step();
      hs_n += int'(vid_hs);
      vs_n += int'(vid_vs);
      de_n += int'(vid_de);
      data_n += int'(vid_data != 24'h0);
      rdy_lo += int'(!in_ready);
      lock_n += int'(locked);
    end
    check_eq("idle_hs_count", hs_n, 30);
    check_eq("idle_vs_count", vs_n, 46);
    check_eq("idle_de_count", de_n, 0);
    check_eq("idle_data_nz", data_n, 0);
    check_eq("idle_ready_low", rdy_lo, 0);
    check_eq("idle_locked", lock_n, 0);

    // Stream joins mid-frame at beat 90; beats 90..95 are discarded, sop beat 96 captured at c=286.
    run_to(279);
    src_k = 90;
    src_on = 1'b1;
    run_to(283);
    check_eq("hunt_discard", vid_data, 0);
    check_eq("hunt_ready", in_ready, 1);
    run_to(300);
    check_eq("wait_ready", in_ready, 0);
    run_to(459);
    check_eq("lock_before_fe", locked, 0);
    run_to(460);
    check_eq("lock_after_fe", locked, 1);
    run_to(461);
    check_eq("first_pix_hold", vid_data, BASE + 24'd96);
    check_eq("first_pix_de", vid_de, 1);
    run_to(462);
    check_eq("pix_1_0", vid_data, BASE + 24'd97);
    run_to(476);
    check_eq("pix_15_0", vid_data, BASE + 24'd111);
    run_to(477);
    check_eq("blank_data", vid_data, 0);
    check_eq("blank_de", vid_de, 0);
    run_to(484);
    check_eq("pix_0_1", vid_data, BASE + 24'd112);
    run_to(591);
    check_eq("pix_15_5", vid_data, BASE + 24'd191);
    run_to(691);
    check_eq("frame3_origin", vid_data, BASE + 24'd192);
    check_eq("frame3_no_serr", sync_err, 0);

    // Underflow at (5,3) of frame 3.
    drop_c = 764;
    run_to(765);
    check_eq("uf_pulse", underflow, 1);
    check_eq("uf_black", vid_data, 0);
    check_eq("uf_unlock", locked, 0);
    run_to(766);
    check_eq("uf_one_cycle", underflow, 0);
    run_to(921);
    check_eq("relock_uf_pix", vid_data, BASE + 24'd288);
    check_eq("relock_uf_lock", locked, 1);
    run_to(922);
    check_eq("relock_uf_next", vid_data, BASE + 24'd289);

    // Stray sop on (10,0) of frame 4.
    sop_c = 930;
    run_to(931);
    check_eq("serr_pulse", sync_err, 1);
    check_eq("serr_black", vid_data, 0);
    check_eq("serr_unlock", locked, 0);
    run_to(932);
    check_eq("serr_one_cycle", sync_err, 0);
    run_to(1151);
    check_eq("relock_serr_pix", vid_data, BASE + 24'd384);

    // One-cycle reset at (8,2) of frame 5.
    drop_c = -1;
    sop_c = -1;
    run_to(1204);
    reset = 1'b1;
    xfer_pend = 1'b0;
    #1 check_eq("mid_rst_ready", in_ready, 0);
    @(negedge vid_clk);
    reset = 1'b0;
    cyc = 0;
    #1;
    check_eq("mid_rst_outputs", {vid_data, vid_hs, vid_vs, vid_de, locked, underflow, sync_err}, 0);
    check_eq("mid_rst_state", dbg_state, 0);
    xfer_pend = in_valid && in_ready;
    run_to(18);
    check_eq("restart_hs_pre", vid_hs, 0);
    run_to(19);
    check_eq("restart_hs_on", vid_hs, 1);
    check_eq("restart_flags", {locked, underflow, sync_err}, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
